switch_debouncer: RTL and testbench

//   Upstream conditioning stage for the board switches feeding `system`'s
//   `switches` input.
//   - Synchronises each raw asynchronous switch bit into the `clock` domain.
//   - Debounces each bit independently with a stability counter.
//   - Outputs a clean level per bit, plus a one-cycle per-bit change strobe that
//     I/O programs can use instead of polling.

---
 rtl/switch_debouncer.sv | 88 ++++++++
 tb/tb_switch_debouncer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions raw, asynchronous board switch pins for use in the clock domain.
// Each bit passes through a two-flop synchroniser and then its own stability
// counter. The result is a clean level per bit and a one-cycle change strobe
// per bit.
//
// Per-bit state (implicit in sync2 vs clean):
//   state   | meaning
//   STABLE  | sync2 == clean, counter held at 0
//   PENDING | sync2 != clean, counter counts consecutive differing edges
//
// A commit happens on the edge where the bit is PENDING and the counter
// already holds DEBOUNCE_CYCLES-1. On that edge the clean level follows sync2,
// the counter returns to 0 and the strobe fires. If sync2 falls back to the
// clean level before that edge, the counter clears and nothing is reported.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches_clean,
  output logic [WIDTH-1:0] changed_mask,
  output logic             changed
);

  // Counter value on the edge where a pending change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state logic: synchroniser shift plus per-bit debounce decision.
  always_comb begin
    sync1_d = switches_raw;
    sync2_d = sync1_q;
    clean_d = clean_q;
    mask_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          mask_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    changed_d = |mask_d;
  end

  // State registers; reset clears every flop, discarding any pending change.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clean_q   <= clean_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switches_clean = clean_q;
  assign changed_mask   = mask_q;
  assign changed        = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Directed stimulus pushes the expected commit (cycle, mask, clean level) into
// a queue; an independent monitor pops an entry every time the DUT strobes.
// A commit is expected on edge k+10 when the new raw level is driven just
// after edge k, since edge k+1 is the one that samples it into sync1.
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int DC = 8;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] clean;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [W-1:0] switches_raw;
  logic [W-1:0] switches_clean;
  logic [W-1:0] changed_mask;
  logic         changed;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clock          (clock),
    .reset          (reset),
    .switches_raw   (switches_raw),
    .switches_clean (switches_clean),
    .changed_mask   (changed_mask),
    .changed        (changed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_check++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge before driving.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive a new raw value and register the commit it must produce.
  task automatic drive_commit(input logic [3:0] raw, input logic [3:0] mask,
                              input logic [3:0] clean);
    exp_t e;
    switches_raw = raw;
    e.cyc   = cyc + DC + 2;
    e.mask  = mask;
    e.clean = clean;
    exp_q.push_back(e);
  endtask

  // Monitor: strobe consistency every cycle, scoreboard pop on each strobe.
  always @(negedge clock) begin
    exp_t e;
    chk("changed_vs_mask", {31'd0, changed}, {31'd0, |changed_mask});
    if (changed || (|changed_mask)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {28'd0, changed_mask}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
        if (e.cyc != cyc) $display("  commit seen at cycle %0d, required %0d", cyc, e.cyc);
        chk("commit_mask", {28'd0, changed_mask}, {28'd0, e.mask});
        chk("commit_clean", {28'd0, switches_clean}, {28'd0, e.clean});
      end
    end
  end

  initial begin
    int k;
    exp_t e;
    // 1. Reset sweep: raw=1010 through reset; first post-reset edge is cycle 2.
    reset        = 1'b1;
    switches_raw = 4'b1010;
    e.cyc = 11; e.mask = 4'b1010; e.clean = 4'b1010;
    exp_q.push_back(e);
    #7 reset = 1'b0;
    @(negedge clock);
    chk("reset_clean", {28'd0, switches_clean}, 32'd0);
    chk("reset_mask", {28'd0, changed_mask}, 32'd0);
    chk("reset_changed", {31'd0, changed}, 32'd0);
    repeat (9) @(negedge clock);
    chk("t1_clean_edge9", {28'd0, switches_clean}, 32'd0);
    step(3);
    drive_commit(4'b0000, 4'b1010, 4'b0000);
    step(14);

    // 2. Clean step on bit 0; must not appear on edge 9.
    drive_commit(4'b0001, 4'b0001, 4'b0001);
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("t2_clean_edge9", {28'd0, switches_clean}, 32'd0);
    step(6);

    // 3. Bounce rejection on bit 2: 5 high, 2 low, four times.
    for (int r = 0; r < 4; r++) begin
      switches_raw = 4'b0101;
      step(5);
      switches_raw = 4'b0001;
      step(2);
    end
    step(14);
    chk("t3_clean", {28'd0, switches_clean}, 32'd1);

    // 4. Bounce then settle on bit 3.
    switches_raw = 4'b1001;
    step(3);
    switches_raw = 4'b0001;
    step(1);
    drive_commit(4'b1001, 4'b1000, 4'b1001);
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("t4_clean_edge9", {28'd0, switches_clean}, 32'd1);
    step(6);

    // 5. Simultaneous bits.
    drive_commit(4'b0000, 4'b1001, 4'b0000);
    step(14);
    drive_commit(4'b1111, 4'b1111, 4'b1111);
    step(14);
    drive_commit(4'b0000, 4'b1111, 4'b0000);
    step(14);

    // 6. Reset mid-pending: counter reaches 5 after edge k+7, reset on k+8.
    k = cyc;
    switches_raw = 4'b0010;
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    e.cyc = k + 8 + DC + 2; e.mask = 4'b0010; e.clean = 4'b0010;
    exp_q.push_back(e);
    @(negedge clock);
    chk("t6_reset_clean", {28'd0, switches_clean}, 32'd0);
    chk("t6_reset_mask", {28'd0, changed_mask}, 32'd0);
    step(14);

    // Drain: every expected commit must have been observed.
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clock);
    step(4);
    chk("pending_expectations", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
